// File: rtl/rom_fetch_if.sv
// Fetch-controller bus: ROM read ports, branch/halt control and the decode slot.
// master = fetch controller, slave = ROM/decode/control side.
interface rom_fetch_if;
  logic       rom_en_read;
  logic       rom_en_read1;
  logic       rom_en_read2;
  logic [7:0] rom_addr1;
  logic [7:0] rom_addr2;
  logic [7:0] rom_data1;
  logic [7:0] rom_data2;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       halt;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       instr_len;
  logic [7:0] instr_pc;
  logic [7:0] pc;
  logic       halted;

  modport master (
    output rom_en_read, rom_en_read1, rom_en_read2, rom_addr1, rom_addr2,
    input  rom_data1, rom_data2,
    input  branch_valid, branch_target, halt,
    output instr_valid, instr_opcode, instr_operand, instr_len, instr_pc,
    input  instr_ready,
    output pc, halted
  );

  modport slave (
    input  rom_en_read, rom_en_read1, rom_en_read2, rom_addr1, rom_addr2,
    output rom_data1, rom_data2,
    output branch_valid, branch_target, halt,
    input  instr_valid, instr_opcode, instr_operand, instr_len, instr_pc,
    output instr_ready,
    input  pc, halted
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer for a dual-read-port 256x8 ROM: reads pc and pc+1
// together, decodes 1/2-byte length and presents one instruction per cycle to decode.
//
// state  | meaning
// RUN    | fetching
// STALL  | slot full and not accepted
// HALTED | fetch stopped by HALT_OPCODE; only a branch or reset leaves
module rom_fetch_ctrl #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         LONG_BIT    = 7,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input logic         clk,
  input logic         rst,
  rom_fetch_if.master bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [7:0] pc_q;
  logic       valid_q;
  logic [7:0] opcode_q;
  logic [7:0] operand_q;
  logic       len_q;
  logic [7:0] ipc_q;
  logic       load;
  logic       fetch_len;

  assign fetch_len = bus.rom_data1[LONG_BIT];

  // The slot is reloaded whenever it is empty or being drained this cycle.
  assign load = (state != HALTED) && !bus.halt && !bus.branch_valid &&
                (!valid_q || bus.instr_ready);

  assign bus.rom_en_read  = load;
  assign bus.rom_en_read1 = load;
  assign bus.rom_en_read2 = load;
  assign bus.rom_addr1    = pc_q;
  assign bus.rom_addr2    = pc_q + 8'd1;

  assign bus.instr_valid   = valid_q;
  assign bus.instr_opcode  = opcode_q;
  assign bus.instr_operand = operand_q;
  assign bus.instr_len     = len_q;
  assign bus.instr_pc      = ipc_q;
  assign bus.pc            = pc_q;
  assign bus.halted        = (state == HALTED);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.branch_valid) begin
      state_next = RUN;
    end else begin
      case (state)
        HALTED: state_next = HALTED;
        default: begin
          if (load)
            state_next = (bus.rom_data1 == HALT_OPCODE) ? HALTED : RUN;
          else if (valid_q && !bus.instr_ready)
            state_next = STALL;
          else
            state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      len_q     <= 1'b0;
      ipc_q     <= 8'h00;
    end else if (bus.branch_valid) begin
      // Redirect flushes the slot even if decode is accepting it this cycle.
      pc_q    <= bus.branch_target;
      valid_q <= 1'b0;
    end else if (load) begin
      opcode_q  <= bus.rom_data1;
      len_q     <= fetch_len;
      operand_q <= fetch_len ? bus.rom_data2 : 8'h00;
      ipc_q     <= pc_q;
      valid_q   <= 1'b1;
      pc_q      <= pc_q + (fetch_len ? 8'd2 : 8'd1);
    end else if (valid_q && bus.instr_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Directed bench for rom_fetch_ctrl: a vector table for the main fetch flow plus
// hand-written sequences for reset priority and pc wrap-around.
module tb_rom_fetch_ctrl;

  logic clk;
  logic rst;
  rom_fetch_if bus ();

  rom_fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [7:0] rom [256];
  assign bus.rom_data1 = rom[bus.rom_addr1];
  assign bus.rom_data2 = rom[bus.rom_addr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       halt;
    logic       bv;
    logic [7:0] bt;
    logic       rdy;
    logic       en;
    logic       valid;
    logic [7:0] opc;
    logic [7:0] opr;
    logic       len;
    logic [7:0] ipc;
    logic [7:0] pc;
    logic       halted;
  } vec_t;

  vec_t vecs [20];

  task automatic check_slot(input string tag, input logic valid, input logic [7:0] opc,
                            input logic [7:0] opr, input logic len, input logic [7:0] ipc,
                            input logic [7:0] pc, input logic halted);
    chk({tag, " valid"},   {7'd0, bus.instr_valid}, {7'd0, valid});
    chk({tag, " opcode"},  bus.instr_opcode, opc);
    chk({tag, " operand"}, bus.instr_operand, opr);
    chk({tag, " len"},     {7'd0, bus.instr_len}, {7'd0, len});
    chk({tag, " ipc"},     bus.instr_pc, ipc);
    chk({tag, " pc"},      bus.pc, pc);
    chk({tag, " halted"},  {7'd0, bus.halted}, {7'd0, halted});
  endtask

  task automatic chk_en(input string tag, input logic exp);
    chk({tag, " en_read"},  {7'd0, bus.rom_en_read},  {7'd0, exp});
    chk({tag, " en_read1"}, {7'd0, bus.rom_en_read1}, {7'd0, exp});
    chk({tag, " en_read2"}, {7'd0, bus.rom_en_read2}, {7'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[8'h00] = 8'h12; rom[8'h01] = 8'h85; rom[8'h02] = 8'h34;
    rom[8'h03] = 8'h05; rom[8'h04] = 8'h06;
    rom[8'h10] = 8'h20;
    rom[8'h40] = 8'h83; rom[8'h41] = 8'h55;
    rom[8'h42] = 8'h07; rom[8'h43] = 8'hFF; rom[8'h44] = 8'h11;
    rom[8'hFF] = 8'h80;

    //          halt bv  bt     rdy  en  val opc    opr    len ipc    pc     halted
    vecs[0]  = '{0, 0, 8'h00, 1,   1,  1, 8'h12, 8'h00, 0, 8'h00, 8'h01, 0};
    vecs[1]  = '{0, 0, 8'h00, 1,   1,  1, 8'h85, 8'h34, 1, 8'h01, 8'h03, 0};
    vecs[2]  = '{0, 0, 8'h00, 0,   0,  1, 8'h85, 8'h34, 1, 8'h01, 8'h03, 0};
    vecs[3]  = '{0, 0, 8'h00, 0,   0,  1, 8'h85, 8'h34, 1, 8'h01, 8'h03, 0};
    vecs[4]  = '{0, 0, 8'h00, 0,   0,  1, 8'h85, 8'h34, 1, 8'h01, 8'h03, 0};
    vecs[5]  = '{0, 0, 8'h00, 1,   1,  1, 8'h05, 8'h00, 0, 8'h03, 8'h04, 0};
    vecs[6]  = '{0, 0, 8'h00, 1,   1,  1, 8'h06, 8'h00, 0, 8'h04, 8'h05, 0};
    vecs[7]  = '{0, 1, 8'h40, 0,   0,  0, 8'h06, 8'h00, 0, 8'h04, 8'h40, 0};
    vecs[8]  = '{0, 0, 8'h00, 1,   1,  1, 8'h83, 8'h55, 1, 8'h40, 8'h42, 0};
    vecs[9]  = '{1, 0, 8'h00, 1,   0,  0, 8'h83, 8'h55, 1, 8'h40, 8'h42, 0};
    vecs[10] = '{1, 0, 8'h00, 1,   0,  0, 8'h83, 8'h55, 1, 8'h40, 8'h42, 0};
    vecs[11] = '{0, 0, 8'h00, 1,   1,  1, 8'h07, 8'h00, 0, 8'h42, 8'h43, 0};
    vecs[12] = '{0, 0, 8'h00, 1,   1,  1, 8'hFF, 8'h11, 1, 8'h43, 8'h45, 1};
    vecs[13] = '{0, 0, 8'h00, 0,   0,  1, 8'hFF, 8'h11, 1, 8'h43, 8'h45, 1};
    vecs[14] = '{0, 0, 8'h00, 1,   0,  0, 8'hFF, 8'h11, 1, 8'h43, 8'h45, 1};
    vecs[15] = '{0, 0, 8'h00, 1,   0,  0, 8'hFF, 8'h11, 1, 8'h43, 8'h45, 1};
    vecs[16] = '{1, 1, 8'h10, 1,   0,  0, 8'hFF, 8'h11, 1, 8'h43, 8'h10, 0};
    vecs[17] = '{0, 0, 8'h00, 1,   1,  1, 8'h20, 8'h00, 0, 8'h10, 8'h11, 0};
    vecs[18] = '{1, 0, 8'h00, 0,   0,  1, 8'h20, 8'h00, 0, 8'h10, 8'h11, 0};
    vecs[19] = '{1, 0, 8'h00, 0,   0,  1, 8'h20, 8'h00, 0, 8'h10, 8'h11, 0};

    rst = 1'b1;
    bus.halt = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = 8'h00;
    bus.instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_slot("reset", 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < 20; i++) begin
      bus.halt          = vecs[i].halt;
      bus.branch_valid  = vecs[i].bv;
      bus.branch_target = vecs[i].bt;
      bus.instr_ready   = vecs[i].rdy;
      #1;
      chk_en($sformatf("v%0d", i), vecs[i].en);
      @(posedge clk);
      #1;
      check_slot($sformatf("v%0d", i), vecs[i].valid, vecs[i].opc, vecs[i].opr,
                 vecs[i].len, vecs[i].ipc, vecs[i].pc, vecs[i].halted);
    end

    // Reset mid-stall, asserted together with a branch: reset wins.
    rst = 1'b1;
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'h77;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.branch_valid = 1'b0;
    bus.halt = 1'b0;
    bus.instr_ready = 1'b1;
    check_slot("rst_mid", 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0);

    // Branch to the top of the address space; the 2-byte fetch wraps.
    rom[8'h00] = 8'hAA;
    bus.branch_valid = 1'b1;
    bus.branch_target = 8'hFF;
    #1;
    chk_en("wrap_br", 1'b0);
    @(posedge clk);
    #1;
    bus.branch_valid = 1'b0;
    #1;
    chk("wrap addr1", bus.rom_addr1, 8'hFF);
    chk("wrap addr2", bus.rom_addr2, 8'h00);
    chk_en("wrap_ld", 1'b1);
    @(posedge clk);
    #1;
    check_slot("wrap", 1, 8'h80, 8'hAA, 1, 8'hFF, 8'h01, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
